multiplication: RTL and testbench

MULTIPLICATION -- requirements
Module: multiplication

---
 rtl/multiplication.sv | 127 ++++++++++++
 tb/tb_multiplication.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multiplication.sv
// Sequential shift-and-add unsigned multiplier: n iterations per operation,
// low n product bits reported on result with overflow flagging the lost high half.
module multiplication #(
    parameter int n = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] b1,
    input  logic [n-1:0] b2,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result,
    output logic         overflow
);

    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(n - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*n-1:0]  mcand_q, mcand_d;
    logic [n-1:0]    mplier_q, mplier_d;
    logic [2*n-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [n-1:0]    result_q, result_d;
    logic            overflow_q, overflow_d;

    // Next-state, datapath and output computation.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        // Outputs are registered views of the state just left, so the
        // visible busy window is n cycles and done lands n+1 edges after start.
        busy_d     = (state_q == S_BUSY);
        done_d     = (state_q == S_DONE);
        result_d   = result_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{n{1'b0}}, b1};
                    mplier_d = b2;
                    acc_d    = {(2*n){1'b0}};
                    cnt_d    = {CW{1'b0}};
                    state_d  = S_BUSY;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                result_d   = acc_q[n-1:0];
                overflow_d = |acc_q[2*n-1:n];
                if (start) begin
                    mcand_d  = {{n{1'b0}}, b1};
                    mplier_d = b2;
                    acc_d    = {(2*n){1'b0}};
                    cnt_d    = {CW{1'b0}};
                    state_d  = S_BUSY;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mcand_q    <= {(2*n){1'b0}};
            mplier_q   <= {n{1'b0}};
            acc_q      <= {(2*n){1'b0}};
            cnt_q      <= {CW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= {n{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_multiplication.sv
// Self-checking bench for multiplication: directed corner cases plus random
// operands checked against an arithmetic product model.
module tb_multiplication;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] b1 = '0;
    logic [N-1:0] b2 = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         overflow;

    int total = 0;
    int bad = 0;
    logic [N-1:0] last_res = '0;
    logic         last_ovf = 1'b0;

    multiplication #(.n(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .b1       (b1),
        .b2       (b2),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected low bits and overflow from the true integer product.
    function automatic int ref_res(input int a, input int b);
        return (a * b) % (1 << N);
    endfunction

    function automatic int ref_ovf(input int a, input int b);
        return ((a * b) > ((1 << N) - 1)) ? 1 : 0;
    endfunction

    // Called #1 after the accepting edge. Counts edges until done; checks
    // outputs hold steady meanwhile. inject_at>0 pulses start with junk operands.
    task automatic wait_done(input int inject_at, input bit scramble, output int edges, output int bcnt);
        edges = -1;
        bcnt = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = e;
                break;
            end
            if (busy) bcnt++;
            if (result !== last_res || overflow !== last_ovf) begin
                check_val("hold_during_busy", {result, overflow}, {last_res, last_ovf});
            end
            if (inject_at > 0 && e == inject_at) begin
                start = 1'b1;
                b1 = N'($urandom);
                b2 = N'($urandom);
            end else begin
                start = 1'b0;
            end
            if (scramble) begin
                b1 = N'($urandom);
                b2 = N'($urandom);
            end
        end
        if (edges < 0) check_val("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input int a, input int b, input int inject_at, input bit scramble, input string tag);
        int edges;
        int bcnt;
        @(negedge clk);
        b1 = N'(a);
        b2 = N'(b);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(inject_at, scramble, edges, bcnt);
        check_val({tag, "_latency"}, edges, N + 1);
        check_val({tag, "_busy_cycles"}, bcnt, N);
        check_val({tag, "_result"}, result, ref_res(a, b));
        check_val({tag, "_overflow"}, overflow, ref_ovf(a, b));
        last_res = N'(ref_res(a, b));
        last_ovf = ref_ovf(a, b) != 0;
        @(posedge clk);
        #1;
        check_val({tag, "_done_single"}, done, 1'b0);
        check_val({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int edges;
        int bcnt;
        int done_seen;

        #1;
        check_val("reset_outputs", {busy, done, result, overflow}, '0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3, 5, 0, 1'b0, "dir_3x5");
        run_op(63, 63, 0, 1'b0, "dir_63x63");
        run_op(8, 8, 0, 1'b0, "dir_8x8");
        run_op(7, 9, 0, 1'b0, "dir_7x9");
        run_op(0, 0, 0, 1'b0, "dir_zero");
        run_op(11, 13, 3, 1'b0, "start_in_busy");
        run_op(37, 22, 0, 1'b1, "operand_change");

        // start held high through DONE: second op follows with no IDLE gap.
        @(negedge clk);
        b1 = N'(5);
        b2 = N'(9);
        start = 1'b1;
        @(posedge clk);
        #1;
        b1 = N'(2);
        b2 = N'(3);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            edges = e;
            if (done) break;
        end
        check_val("b2b_first_latency", edges, N + 1);
        check_val("b2b_first_result", {result, overflow}, {N'(ref_res(5, 9)), ref_ovf(5, 9) != 0});
        check_val("b2b_busy_low_in_done", busy, 1'b0);
        start = 1'b0;
        last_res = N'(ref_res(5, 9));
        last_ovf = ref_ovf(5, 9) != 0;
        wait_done(0, 1'b0, edges, bcnt);
        check_val("b2b_second_latency", edges, N + 1);
        check_val("b2b_second_busy", bcnt, N);
        check_val("b2b_second_result", {result, overflow}, {N'(6), 1'b0});
        last_res = N'(6);
        last_ovf = 1'b0;

        // Reset during busy cycle 4 aborts without a done pulse.
        @(negedge clk);
        b1 = N'(9);
        b2 = N'(7);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("abort_outputs", {busy, done, result, overflow}, '0);
        last_res = '0;
        last_ovf = 1'b0;
        done_seen = 0;
        start = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        start = 1'b0;
        check_val("abort_no_activity", done_seen, 0);
        rst_n = 1'b1;
        run_op(0, 45, 0, 1'b0, "post_reset_0x45");

        for (int i = 0; i < 20; i++) begin
            int a;
            int b;
            a = int'($urandom_range((1 << N) - 1, 0));
            b = int'($urandom_range((1 << N) - 1, 0));
            run_op(a, b, (i % 3 == 0) ? int'($urandom_range(N - 1, 1)) : 0, i[0], "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
